capture_sequencer: RTL and testbench

CAPTURE_SEQUENCER -- requirements
Module: capture_sequencer

---
 rtl/capture_pkg.sv | 38 +++
 rtl/sample_serializer.sv | 70 +++++++
 rtl/capture_sequencer.sv | 163 ++++++++++++++++
 tb/tb_capture_sequencer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// capture_pkg
//   Shared types and helpers for the capture sequencer and its byte serializer.
//   - state_t          : sequencer states, IDLE through WAIT
//   - BYTES_PER_SAMPLE : bytes per sample at the default 8-bit sample width
//   - bytes_per_sample : the same figure for any sample width
//   - scaled_count     : turns a 16-bit configuration field into a sample count
package capture_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ARMED     = 3'd1,
      ST_TRIGGERED = 3'd2,
      ST_READ      = 3'd3,
      ST_LOAD      = 3'd4,
      ST_SEND      = 3'd5,
      ST_WAIT      = 3'd6
   } state_t;

   localparam int unsigned DEFAULT_SAMPLE_WIDTH = 8;
   localparam int unsigned BYTES_PER_SAMPLE     = DEFAULT_SAMPLE_WIDTH / 8;

   function automatic int unsigned bytes_per_sample(input int unsigned sample_width);
      return sample_width / 8;
   endfunction

   // A field value f means 4*(f+1) samples; the result never exceeds the buffer depth.
   function automatic logic [31:0] scaled_count(input logic [15:0] field,
                                                input logic [31:0] depth);
      logic [31:0] value;
      value = ({16'd0, field} + 32'd1) << 2;
      if (value > depth) begin
         return depth;
      end else begin
         return value;
      end
   endfunction

endpackage

// File: rtl/sample_serializer.sv
// sample_serializer
//   Sends one buffered sample to the UART as bytes, least significant byte first.
//   Ports:
//   - clock, reset   : rising-edge clock, synchronous active-high reset
//   - load           : capture rdata into the shift register and restart at byte 0
//   - send_en        : the sequencer is waiting to start a byte
//   - wait_en        : the sequencer is waiting for the UART to finish a byte
//   - rdata          : sample read back from the buffer
//   - transmit_busy  : UART transmitter busy
//   - tx_start       : one-cycle start pulse, tx_data : byte to send
//   - byte_done      : a byte has finished and more bytes remain
//   - sample_done    : the last byte of the sample has finished
module sample_serializer
   import capture_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 8,
   parameter int BYTES        = BYTES_PER_SAMPLE
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    load,
   input  logic                    send_en,
   input  logic                    wait_en,
   input  logic [SAMPLE_WIDTH-1:0] rdata,
   input  logic                    transmit_busy,
   output logic                    tx_start,
   output logic [7:0]              tx_data,
   output logic                    byte_done,
   output logic                    sample_done
);

   localparam int IW = $clog2(BYTES + 1);

   logic [SAMPLE_WIDTH-1:0] shift_r;
   logic [IW-1:0]           idx_r;
   logic                    skip_r;
   logic                    tx_start_s;
   logic                    wait_ok_s;
   logic                    last_s;

   // A start is only ever issued while the transmitter reports idle.
   assign tx_start_s = send_en & ~transmit_busy;
   // The cycle right after a start is ignored: the UART may not have raised busy yet.
   assign wait_ok_s  = wait_en & ~skip_r & ~transmit_busy;
   assign last_s     = (idx_r == IW'(BYTES));

   assign tx_start    = tx_start_s;
   assign tx_data     = shift_r[7:0];
   assign byte_done   = wait_ok_s & ~last_s;
   assign sample_done = wait_ok_s & last_s;

   // Shift register, count of bytes sent, and the flag that skips the first wait cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         shift_r <= {SAMPLE_WIDTH{1'b0}};
         idx_r   <= {IW{1'b0}};
         skip_r  <= 1'b0;
      end else begin
         skip_r <= tx_start_s;
         if (load) begin
            shift_r <= rdata;
            idx_r   <= {IW{1'b0}};
         end else if (tx_start_s) begin
            shift_r <= shift_r >> 4'd8;
            idx_r   <= idx_r + IW'(1);
         end
      end
   end

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer
//   Logic-analyser capture control: when armed, it writes samples into a circular
//   buffer. On a trigger it captures a configurable number of further samples, then
//   reads a configurable number back, newest first, and sends them byte-wise to a UART.
//   Ports:
//   - clock, reset             : rising-edge clock, synchronous active-high reset
//   - cfg_load, cfg_word       : load read count [15:0] and delay count [31:16] (in IDLE only)
//   - arm, finish_now, run     : start capture, force trigger, trigger level
//   - sample_valid, sample_in  : sample strobe and data
//   - mem_*                    : buffer write port and read address (data returns next cycle)
//   - transmit_busy, tx_start, tx_data : UART handshake
//   - armed, triggered, sending: status flags
module capture_sequencer
   import capture_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 8,
   parameter int ADDR_WIDTH   = 10
)(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cfg_load,
   input  logic [31:0]             cfg_word,
   input  logic                    arm,
   input  logic                    finish_now,
   input  logic                    run,
   input  logic                    sample_valid,
   input  logic [SAMPLE_WIDTH-1:0] sample_in,
   input  logic [SAMPLE_WIDTH-1:0] mem_rdata,
   input  logic                    transmit_busy,
   output logic                    mem_we,
   output logic [ADDR_WIDTH-1:0]   mem_waddr,
   output logic [SAMPLE_WIDTH-1:0] mem_wdata,
   output logic [ADDR_WIDTH-1:0]   mem_raddr,
   output logic                    tx_start,
   output logic [7:0]              tx_data,
   output logic                    armed,
   output logic                    triggered,
   output logic                    sending
);

   // Counts run up to the full depth, so they need one bit more than an address.
   localparam int          CW      = ADDR_WIDTH + 1;
   localparam logic [31:0] DEPTH_W = 32'd1 << ADDR_WIDTH;

   state_t                state_r;
   state_t                state_s;
   logic [ADDR_WIDTH-1:0] wptr_r;
   logic [ADDR_WIDTH-1:0] raddr_r;
   logic [CW-1:0]         delay_cnt_r;
   logic [CW-1:0]         remaining_r;
   logic [CW-1:0]         read_samples_r;
   logic [CW-1:0]         delay_samples_r;
   logic                  write_s;
   logic                  trig_s;
   logic                  ser_tx_start_s;
   logic                  ser_byte_done_s;
   logic                  ser_sample_done_s;

   assign write_s = ~reset & sample_valid &
                    ((state_r == ST_ARMED) || (state_r == ST_TRIGGERED));
   assign trig_s  = run | finish_now;

   // Next-state selection; only IDLE reacts to arm, only ARMED reacts to the trigger.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (arm) state_s = ST_ARMED;
            else     state_s = ST_IDLE;
         end
         ST_ARMED: begin
            if (trig_s) state_s = ST_TRIGGERED;
            else        state_s = ST_ARMED;
         end
         ST_TRIGGERED: begin
            if (write_s && (delay_cnt_r == CW'(1))) state_s = ST_READ;
            else                                    state_s = ST_TRIGGERED;
         end
         ST_READ: state_s = ST_LOAD;
         ST_LOAD: state_s = ST_SEND;
         ST_SEND: begin
            if (ser_tx_start_s) state_s = ST_WAIT;
            else                state_s = ST_SEND;
         end
         ST_WAIT: begin
            if (ser_sample_done_s) begin
               if (remaining_r > CW'(1)) state_s = ST_READ;
               else                      state_s = ST_IDLE;
            end else if (ser_byte_done_s) begin
               state_s = ST_SEND;
            end else begin
               state_s = ST_WAIT;
            end
         end
         default: state_s = ST_IDLE;
      endcase
   end

   // State, pointers and counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r         <= ST_IDLE;
         wptr_r          <= {ADDR_WIDTH{1'b0}};
         raddr_r         <= {ADDR_WIDTH{1'b0}};
         delay_cnt_r     <= {CW{1'b0}};
         remaining_r     <= {CW{1'b0}};
         read_samples_r  <= CW'(scaled_count(16'd0, DEPTH_W));
         delay_samples_r <= CW'(scaled_count(16'd0, DEPTH_W));
      end else begin
         state_r <= state_s;
         if (write_s) begin
            wptr_r <= wptr_r + ADDR_WIDTH'(1);
         end
         if ((state_r == ST_IDLE) && cfg_load) begin
            read_samples_r  <= CW'(scaled_count(cfg_word[15:0], DEPTH_W));
            delay_samples_r <= CW'(scaled_count(cfg_word[31:16], DEPTH_W));
         end
         // A sample written in the trigger cycle is not part of the post-trigger delay.
         if ((state_r == ST_ARMED) && trig_s) begin
            delay_cnt_r <= delay_samples_r;
         end else if ((state_r == ST_TRIGGERED) && write_s) begin
            delay_cnt_r <= delay_cnt_r - CW'(1);
            if (delay_cnt_r == CW'(1)) begin
               raddr_r     <= wptr_r;
               remaining_r <= read_samples_r;
            end
         end
         // Read-back walks backwards so the newest sample goes out first.
         if ((state_r == ST_WAIT) && ser_sample_done_s) begin
            remaining_r <= remaining_r - CW'(1);
            raddr_r     <= raddr_r - ADDR_WIDTH'(1);
         end
      end
   end

   sample_serializer #(
      .SAMPLE_WIDTH (SAMPLE_WIDTH),
      .BYTES        (bytes_per_sample(SAMPLE_WIDTH))
   ) u_serializer (
      .clock         (clock),
      .reset         (reset),
      .load          (state_r == ST_LOAD),
      .send_en       (~reset & (state_r == ST_SEND)),
      .wait_en       (state_r == ST_WAIT),
      .rdata         (mem_rdata),
      .transmit_busy (transmit_busy),
      .tx_start      (ser_tx_start_s),
      .tx_data       (tx_data),
      .byte_done     (ser_byte_done_s),
      .sample_done   (ser_sample_done_s)
   );

   assign mem_we    = write_s;
   assign mem_waddr = wptr_r;
   assign mem_wdata = write_s ? sample_in : {SAMPLE_WIDTH{1'b0}};
   assign mem_raddr = raddr_r;
   assign tx_start  = ser_tx_start_s;
   assign armed     = (state_r == ST_ARMED);
   assign triggered = (state_r == ST_TRIGGERED);
   assign sending   = (state_r == ST_READ) || (state_r == ST_LOAD) ||
                      (state_r == ST_SEND) || (state_r == ST_WAIT);

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer
//   Two instances share one control sequence: "a" uses the default parameters (8-bit
//   samples, 1024-deep buffer), "b" uses 16-bit samples in a 16-deep buffer. Instance b
//   receives {s ^ 8'h51, s} for each base sample s, so base 0xEF arrives as 0xBEEF.
//   Each instance has its own buffer and UART model. Expected bytes are worked out by hand.
module tb_capture_sequencer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic        reset, cfg_load, arm, finish_now, run, sample_valid, hold_busy;
   logic [31:0] cfg_word;
   logic [7:0]  smp;

   logic [7:0]  a_sample_in, a_rdata, a_wdata, a_tx_data;
   logic [9:0]  a_waddr, a_raddr;
   logic        a_we, a_tx_start, a_armed, a_triggered, a_sending, a_busy;
   logic [15:0] b_sample_in, b_rdata, b_wdata;
   logic [7:0]  b_tx_data;
   logic [3:0]  b_waddr, b_raddr;
   logic        b_we, b_tx_start, b_armed, b_triggered, b_sending, b_busy;

   assign a_sample_in = smp;
   assign b_sample_in = {smp ^ 8'h51, smp};

   capture_sequencer u_dut_a (
      .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_word(cfg_word),
      .arm(arm), .finish_now(finish_now), .run(run), .sample_valid(sample_valid),
      .sample_in(a_sample_in), .mem_rdata(a_rdata), .transmit_busy(a_busy),
      .mem_we(a_we), .mem_waddr(a_waddr), .mem_wdata(a_wdata), .mem_raddr(a_raddr),
      .tx_start(a_tx_start), .tx_data(a_tx_data), .armed(a_armed),
      .triggered(a_triggered), .sending(a_sending));

   capture_sequencer #(.SAMPLE_WIDTH(16), .ADDR_WIDTH(4)) u_dut_b (
      .clock(clock), .reset(reset), .cfg_load(cfg_load), .cfg_word(cfg_word),
      .arm(arm), .finish_now(finish_now), .run(run), .sample_valid(sample_valid),
      .sample_in(b_sample_in), .mem_rdata(b_rdata), .transmit_busy(b_busy),
      .mem_we(b_we), .mem_waddr(b_waddr), .mem_wdata(b_wdata), .mem_raddr(b_raddr),
      .tx_start(b_tx_start), .tx_data(b_tx_data), .armed(b_armed),
      .triggered(b_triggered), .sending(b_sending));

   // Buffer and UART models: each UART stays busy for 3 cycles after every start.
   logic [7:0]  a_mem [0:1023];
   logic [15:0] b_mem [0:15];
   logic [7:0]  a_q[$];
   logic [7:0]  b_q[$];
   logic [3:0]  b_wlog[$];
   int a_cnt = 0, b_cnt = 0, a_wr = 0, b_wr = 0, a_viol = 0, b_viol = 0;
   assign a_busy = hold_busy || (a_cnt != 0);
   assign b_busy = hold_busy || (b_cnt != 0);

   always @(posedge clock) begin
      if (a_we) begin a_mem[a_waddr] <= a_wdata; a_wr <= a_wr + 1; end
      a_rdata <= a_mem[a_raddr];
      if (a_tx_start) begin
         a_q.push_back(a_tx_data);
         if (a_busy) a_viol <= a_viol + 1;
         a_cnt <= 3;
      end else if (a_cnt != 0) a_cnt <= a_cnt - 1;
   end

   always @(posedge clock) begin
      if (b_we) begin b_mem[b_waddr] <= b_wdata; b_wr <= b_wr + 1; b_wlog.push_back(b_waddr); end
      b_rdata <= b_mem[b_raddr];
      if (b_tx_start) begin
         b_q.push_back(b_tx_data);
         if (b_busy) b_viol <= b_viol + 1;
         b_cnt <= 3;
      end else if (b_cnt != 0) b_cnt <= b_cnt - 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int total = 0, bad = 0;
   int qa0, qb0, wa0, wb0, lb0;
   logic [7:0] ea [8];
   logic [7:0] eb [8];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic feed(input logic [7:0] v);
      smp = v; sample_valid = 1'b1; step();
      sample_valid = 1'b0; step();
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((a_sending || b_sending || a_armed || b_armed || a_triggered || b_triggered)
             && (n < 1000)) begin
         step();
         n++;
      end
      chk(tag, 32'(n < 1000), 32'd1);
   endtask

   task automatic mark();
      qa0 = a_q.size(); qb0 = b_q.size(); wa0 = a_wr; wb0 = b_wr; lb0 = b_wlog.size();
   endtask

   task automatic check_bytes(input string tag, input int na, input int nb);
      chk({tag, "_na"}, 32'(a_q.size() - qa0), 32'(na));
      chk({tag, "_nb"}, 32'(b_q.size() - qb0), 32'(nb));
      for (int i = 0; i < na; i++)
         chk({tag, "_a"}, (qa0 + i < a_q.size()) ? 32'(a_q[qa0 + i]) : 32'hDEAD, 32'(ea[i]));
      for (int i = 0; i < nb; i++)
         chk({tag, "_b"}, (qb0 + i < b_q.size()) ? 32'(b_q[qb0 + i]) : 32'hDEAD, 32'(eb[i]));
   endtask

   initial begin
      reset = 1'b1; cfg_load = 1'b0; arm = 1'b0; finish_now = 1'b0; run = 1'b0;
      sample_valid = 1'b0; hold_busy = 1'b0; cfg_word = 32'd0; smp = 8'd0;
      step(); step();
      reset = 1'b0;
      chk("rst_flags_a", {a_armed, a_triggered, a_sending, a_we, a_tx_start}, 32'd0);
      chk("rst_flags_b", {b_armed, b_triggered, b_sending, b_we, b_tx_start}, 32'd0);
      chk("rst_addr_a", {a_waddr, a_raddr}, 32'd0);

      // Capture with delay 8 and read 4; trigger arrives after 3 samples.
      cfg_word = 32'h0001_0000; cfg_load = 1'b1; step(); cfg_load = 1'b0;
      arm = 1'b1; step(); arm = 1'b0;
      chk("arm_a", 32'(a_armed), 32'd1);
      chk("arm_b", 32'(b_armed), 32'd1);
      mark();
      feed(8'h00); feed(8'h01); feed(8'h02);
      run = 1'b1; step(); run = 1'b0;
      chk("run_trig_a", 32'(a_triggered), 32'd1);
      chk("run_trig_b", 32'(b_triggered), 32'd1);
      for (int i = 3; i < 20; i++) feed(8'(i));
      wait_idle("a_done");
      chk("a_writes_a", 32'(a_wr - wa0), 32'd11);
      chk("a_writes_b", 32'(b_wr - wb0), 32'd11);
      ea = '{8'h0A, 8'h09, 8'h08, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
      eb = '{8'h0A, 8'h5B, 8'h09, 8'h58, 8'h08, 8'h59, 8'h07, 8'h56};
      check_bytes("a_bytes", 4, 8);
      chk("a_idle_a", {a_armed, a_triggered, a_sending}, 32'd0);

      // finish_now in IDLE does nothing; in ARMED it triggers. The b buffer wraps here.
      cfg_word = 32'h0000_0000; cfg_load = 1'b1; step(); cfg_load = 1'b0;
      finish_now = 1'b1; step(); finish_now = 1'b0;
      chk("fin_idle_a", {a_armed, a_triggered}, 32'd0);
      arm = 1'b1; step(); arm = 1'b0;
      mark();
      feed(8'h30); feed(8'h31); feed(8'h32);
      cfg_word = 32'hFFFF_FFFF; cfg_load = 1'b1; step(); cfg_load = 1'b0; cfg_word = 32'd0;
      finish_now = 1'b1; step(); finish_now = 1'b0;
      chk("fin_trig_a", 32'(a_triggered), 32'd1);
      chk("fin_trig_b", 32'(b_triggered), 32'd1);
      feed(8'hEC); feed(8'hED); feed(8'hEE); feed(8'hEF);
      wait_idle("b_done");
      chk("b_writes_a", 32'(a_wr - wa0), 32'd7);
      chk("b_wlog_len", 32'(b_wlog.size() - lb0), 32'd7);
      for (int i = 0; i < 4; i++)
         chk("b_waddr", (lb0 + 3 + i < b_wlog.size()) ? 32'(b_wlog[lb0 + 3 + i]) : 32'hDEAD,
             32'((14 + i) % 16));
      ea = '{8'hEF, 8'hEE, 8'hED, 8'hEC, 8'h00, 8'h00, 8'h00, 8'h00};
      eb = '{8'hEF, 8'hBE, 8'hEE, 8'hBF, 8'hED, 8'hBC, 8'hEC, 8'hBD};
      check_bytes("b_bytes", 4, 8);

      // Hold the UART busy for 50 cycles while the sequencer waits to send.
      arm = 1'b1; step(); arm = 1'b0;
      run = 1'b1; step(); run = 1'b0;
      mark();
      feed(8'h40); feed(8'h41); feed(8'h42);
      smp = 8'h43; sample_valid = 1'b1; hold_busy = 1'b1; step(); sample_valid = 1'b0;
      repeat (50) step();
      chk("hold_none_a", 32'(a_q.size() - qa0), 32'd0);
      chk("hold_none_b", 32'(b_q.size() - qb0), 32'd0);
      chk("hold_sending_a", 32'(a_sending), 32'd1);
      hold_busy = 1'b0;
      #1;
      chk("release_start_a", 32'(a_tx_start), 32'd1);
      chk("release_start_b", 32'(b_tx_start), 32'd1);
      wait_idle("c_done");
      ea = '{8'h43, 8'h42, 8'h41, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00};
      eb = '{8'h43, 8'h12, 8'h42, 8'h13, 8'h41, 8'h10, 8'h40, 8'h11};
      check_bytes("c_bytes", 4, 8);

      // Reset in the middle of SEND, with arm asserted in the same cycle.
      cfg_word = 32'h0000_0001; cfg_load = 1'b1; step(); cfg_load = 1'b0;
      arm = 1'b1; step(); arm = 1'b0;
      run = 1'b1; step(); run = 1'b0;
      feed(8'h60); feed(8'h61); feed(8'h62);
      smp = 8'h63; sample_valid = 1'b1; hold_busy = 1'b1; step(); sample_valid = 1'b0;
      repeat (5) step();
      chk("pre_rst_sending_a", 32'(a_sending), 32'd1);
      reset = 1'b1; arm = 1'b1; step(); reset = 1'b0; arm = 1'b0; hold_busy = 1'b0;
      chk("mid_rst_flags_a", {a_armed, a_triggered, a_sending, a_we, a_tx_start}, 32'd0);
      chk("mid_rst_flags_b", {b_armed, b_triggered, b_sending, b_we, b_tx_start}, 32'd0);
      chk("mid_rst_addr_a", {a_waddr, a_raddr}, 32'd0);
      chk("mid_rst_data_a", {a_wdata, a_tx_data}, 32'd0);
      chk("mid_rst_out_b", {b_waddr, b_raddr, b_wdata, b_tx_data}, 32'd0);
      mark();
      arm = 1'b1; step(); arm = 1'b0;
      chk("rearm_a", 32'(a_armed), 32'd1);
      run = 1'b1; step(); run = 1'b0;
      feed(8'h50); feed(8'h51); feed(8'h52); feed(8'h53);
      wait_idle("d_done");
      chk("d_first_waddr_b", (lb0 < b_wlog.size()) ? 32'(b_wlog[lb0]) : 32'hDEAD, 32'd0);
      ea = '{8'h53, 8'h52, 8'h51, 8'h50, 8'h00, 8'h00, 8'h00, 8'h00};
      eb = '{8'h53, 8'h02, 8'h52, 8'h03, 8'h51, 8'h00, 8'h50, 8'h01};
      check_bytes("d_bytes", 4, 8);

      chk("busy_violations_a", 32'(a_viol), 32'd0);
      chk("busy_violations_b", 32'(b_viol), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
